// File: rtl/voice_demux_pkg.sv
// Shared constants for the voice demultiplexer: default sizing and the
// encoding of the slot-selection mode input.
package voice_demux_pkg;

    localparam int DEFAULT_M        = 12;
    localparam int DEFAULT_N_VOICES = 4;

    typedef enum logic {
        MODE_EXPLICIT = 1'b0,
        MODE_AUTO     = 1'b1
    } mode_e;

endpackage

// File: rtl/voice_demux_if.sv
// Sample input and held-voice output bundle of the voice demultiplexer.
// The master drives samples and control; the slave (the demux) returns the voices.
interface voice_demux_if
#(
    parameter int M        = voice_demux_pkg::DEFAULT_M,
    parameter int N_VOICES = voice_demux_pkg::DEFAULT_N_VOICES
);
    import voice_demux_pkg::*;

    localparam int SW = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

    logic                  clr;
    mode_e                 mode;
    logic [N_VOICES-1:0]   voice_en;
    logic                  in_valid;
    logic [SW-1:0]         in_sel;
    logic [M-1:0]          in_data;
    logic [N_VOICES*M-1:0] out_data;
    logic [N_VOICES-1:0]   out_upd;
    logic                  frame_done;
    logic                  sel_err;
    logic [SW-1:0]         slot;

    modport master (
        output clr, mode, voice_en, in_valid, in_sel, in_data,
        input  out_data, out_upd, frame_done, sel_err, slot
    );

    modport slave (
        input  clr, mode, voice_en, in_valid, in_sel, in_data,
        output out_data, out_upd, frame_done, sel_err, slot
    );

endinterface

// File: rtl/voice_hold_reg.sv
// One voice's held sample: an M-bit register loaded only when its write
// enable is high, cleared asynchronously by the active-low reset.
module voice_hold_reg
    import voice_demux_pkg::*;
#(
    parameter int M = DEFAULT_M
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we_i,
    input  logic [M-1:0] d_i,
    output logic [M-1:0] q_o
);

    logic [M-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (we_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/voice_demux.sv
// Routes a sample stream to N_VOICES held outputs, either by explicit select
// or round-robin, and flags when every enabled voice has been refreshed.
module voice_demux
    import voice_demux_pkg::*;
#(
    parameter int M        = DEFAULT_M,
    parameter int N_VOICES = DEFAULT_N_VOICES
)
(
    input  logic         clk,
    input  logic         rst_n,
    voice_demux_if.slave bus
);

    localparam int SW = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

    mode_e               mode_q;
    logic [SW-1:0]       slot_q, slot_d;
    logic [N_VOICES-1:0] seen_q, seen_d;
    logic [N_VOICES-1:0] upd_q, upd_d;
    logic                frameDone_q, frameDone_d;
    logic                selErr_q, selErr_d;

    logic                modeChange;
    logic [SW-1:0]       slotEff;
    logic [SW-1:0]       target;
    logic                inRange;
    logic                accept;
    logic [N_VOICES-1:0] seenEff;
    logic [N_VOICES-1:0] covered;
    logic [M-1:0]        holdQ [N_VOICES];

    // A mode switch restarts both the round-robin and the frame from scratch
    // in the same cycle, so the sample arriving with it already sees slot 0.
    always_comb begin
        modeChange  = (bus.mode != mode_q);
        slotEff     = modeChange ? '0 : slot_q;
        seenEff     = modeChange ? '0 : seen_q;
        target      = (bus.mode == MODE_AUTO) ? slotEff : bus.in_sel;
        inRange     = (int'(target) < N_VOICES);
        upd_d       = '0;
        for (int k = 0; k < N_VOICES; k++) begin
            upd_d[k] = bus.in_valid && !bus.clr && (int'(target) == k) && bus.voice_en[k];
        end
        accept      = |upd_d;
        covered     = seenEff | upd_d;
        frameDone_d = accept && (bus.voice_en != '0)
                      && ((covered & bus.voice_en) == bus.voice_en);
        selErr_d    = bus.in_valid && !bus.clr && (bus.mode == MODE_EXPLICIT) && !inRange;

        seen_d = covered;
        if (bus.clr || frameDone_d) begin
            seen_d = '0;
        end

        slot_d = slotEff;
        if (bus.clr) begin
            slot_d = '0;
        end else if ((bus.mode == MODE_AUTO) && bus.in_valid) begin
            slot_d = (int'(slotEff) == N_VOICES - 1) ? '0 : slotEff + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_EXPLICIT;
            slot_q      <= '0;
            seen_q      <= '0;
            upd_q       <= '0;
            frameDone_q <= 1'b0;
            selErr_q    <= 1'b0;
        end else begin
            mode_q      <= bus.mode;
            slot_q      <= slot_d;
            seen_q      <= seen_d;
            upd_q       <= upd_d;
            frameDone_q <= frameDone_d;
            selErr_q    <= selErr_d;
        end
    end

    for (genvar k = 0; k < N_VOICES; k++) begin : gVoice
        voice_hold_reg #(.M(M)) uHold (
            .clk   (clk),
            .rst_n (rst_n),
            .we_i  (upd_d[k]),
            .d_i   (bus.in_data),
            .q_o   (holdQ[k])
        );
    end

    always_comb begin
        bus.out_data = '0;
        for (int k = 0; k < N_VOICES; k++) begin
            bus.out_data[k*M +: M] = holdQ[k];
        end
    end

    assign bus.out_upd    = upd_q;
    assign bus.frame_done = frameDone_q;
    assign bus.sel_err    = selErr_q;
    assign bus.slot       = slot_q;

endmodule

// File: tb/tb_voice_demux.sv
// Directed bench for voice_demux: a vector table on a 4-voice instance plus
// hand sequences for the out-of-range select (3 voices) and mid-frame reset.
module tb_voice_demux;
    import voice_demux_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    voice_demux_if #(.M(12), .N_VOICES(4)) ifA ();
    voice_demux_if #(.M(12), .N_VOICES(3)) ifB ();

    voice_demux #(.M(12), .N_VOICES(4)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA.slave));
    voice_demux #(.M(12), .N_VOICES(3)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB.slave));

    typedef struct {
        logic        clr;
        mode_e       mode;
        logic [3:0]  en;
        logic        valid;
        logic [1:0]  sel;
        logic [11:0] data;
        logic [47:0] expData;
        logic [3:0]  expUpd;
        logic        expFd;
        logic [1:0]  expSlot;
    } vec_t;

    int   vectors    = 0;
    int   miscompares = 0;
    vec_t vecs [26];

    function automatic vec_t mk(input logic clr, input mode_e mode, input logic [3:0] en,
                                input logic valid, input logic [1:0] sel, input logic [11:0] data,
                                input logic [47:0] expData, input logic [3:0] expUpd,
                                input logic expFd, input logic [1:0] expSlot);
        vec_t v;
        v.clr = clr; v.mode = mode; v.en = en; v.valid = valid; v.sel = sel; v.data = data;
        v.expData = expData; v.expUpd = expUpd; v.expFd = expFd; v.expSlot = expSlot;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        ifA.clr      = v.clr;
        ifA.mode     = v.mode;
        ifA.voice_en = v.en;
        ifA.in_valid = v.valid;
        ifA.in_sel   = v.sel;
        ifA.in_data  = v.data;
        @(posedge clk);
        #1;
    endtask

    task automatic driveB(input logic valid, input logic [1:0] sel, input logic [11:0] data);
        @(negedge clk);
        ifB.in_valid = valid;
        ifB.in_sel   = sel;
        ifB.in_data  = data;
        @(posedge clk);
        #1;
    endtask

    task automatic driveA(input logic valid, input logic [11:0] data);
        @(negedge clk);
        ifA.clr      = 1'b0;
        ifA.mode     = MODE_AUTO;
        ifA.voice_en = 4'hF;
        ifA.in_valid = valid;
        ifA.in_sel   = 2'd0;
        ifA.in_data  = data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fdCount;

        rst_n = 1'b0;
        ifA.clr = 1'b0; ifA.mode = MODE_EXPLICIT; ifA.voice_en = 4'hF;
        ifA.in_valid = 1'b0; ifA.in_sel = '0; ifA.in_data = '0;
        ifB.clr = 1'b0; ifB.mode = MODE_EXPLICIT; ifB.voice_en = 3'b111;
        ifB.in_valid = 1'b0; ifB.in_sel = '0; ifB.in_data = '0;

        // Explicit write, full auto round, masked round, clr mid-round,
        // mode switches mid-frame, empty enable mask.
        vecs[0]  = mk(0, MODE_EXPLICIT, 4'hF, 1, 2, 12'h123, 48'h000_123_000_000, 4'b0100, 0, 0);
        vecs[1]  = mk(0, MODE_EXPLICIT, 4'hF, 0, 0, 12'h000, 48'h000_123_000_000, 4'b0000, 0, 0);
        vecs[2]  = mk(0, MODE_AUTO,     4'hF, 1, 0, 12'hA00, 48'h000_123_000_A00, 4'b0001, 0, 1);
        vecs[3]  = mk(0, MODE_AUTO,     4'hF, 1, 0, 12'hA01, 48'h000_123_A01_A00, 4'b0010, 0, 2);
        vecs[4]  = mk(0, MODE_AUTO,     4'hF, 1, 0, 12'hA02, 48'h000_A02_A01_A00, 4'b0100, 0, 3);
        vecs[5]  = mk(0, MODE_AUTO,     4'hF, 1, 0, 12'hA03, 48'hA03_A02_A01_A00, 4'b1000, 1, 0);
        vecs[6]  = mk(0, MODE_AUTO,     4'hA, 1, 0, 12'hB00, 48'hA03_A02_A01_A00, 4'b0000, 0, 1);
        vecs[7]  = mk(0, MODE_AUTO,     4'hA, 1, 0, 12'hB01, 48'hA03_A02_B01_A00, 4'b0010, 0, 2);
        vecs[8]  = mk(0, MODE_AUTO,     4'hA, 1, 0, 12'hB02, 48'hA03_A02_B01_A00, 4'b0000, 0, 3);
        vecs[9]  = mk(0, MODE_AUTO,     4'hA, 1, 0, 12'hB03, 48'hB03_A02_B01_A00, 4'b1000, 1, 0);
        vecs[10] = mk(0, MODE_AUTO,     4'hF, 1, 0, 12'hC00, 48'hB03_A02_B01_C00, 4'b0001, 0, 1);
        vecs[11] = mk(0, MODE_AUTO,     4'hF, 1, 0, 12'hC01, 48'hB03_A02_C01_C00, 4'b0010, 0, 2);
        vecs[12] = mk(1, MODE_AUTO,     4'hF, 1, 0, 12'hC02, 48'hB03_A02_C01_C00, 4'b0000, 0, 0);
        vecs[13] = mk(0, MODE_AUTO,     4'hF, 1, 0, 12'hD00, 48'hB03_A02_C01_D00, 4'b0001, 0, 1);
        vecs[14] = mk(0, MODE_AUTO,     4'hF, 1, 0, 12'hD01, 48'hB03_A02_D01_D00, 4'b0010, 0, 2);
        vecs[15] = mk(0, MODE_AUTO,     4'hF, 1, 0, 12'hD02, 48'hB03_D02_D01_D00, 4'b0100, 0, 3);
        vecs[16] = mk(0, MODE_AUTO,     4'hF, 1, 0, 12'hD03, 48'hD03_D02_D01_D00, 4'b1000, 1, 0);
        vecs[17] = mk(0, MODE_EXPLICIT, 4'hF, 1, 3, 12'hE03, 48'hE03_D02_D01_D00, 4'b1000, 0, 0);
        vecs[18] = mk(0, MODE_AUTO,     4'hF, 1, 0, 12'hF00, 48'hE03_D02_D01_F00, 4'b0001, 0, 1);
        vecs[19] = mk(0, MODE_AUTO,     4'hF, 1, 0, 12'hF01, 48'hE03_D02_F01_F00, 4'b0010, 0, 2);
        vecs[20] = mk(0, MODE_AUTO,     4'hF, 1, 0, 12'hF02, 48'hE03_F02_F01_F00, 4'b0100, 0, 3);
        vecs[21] = mk(0, MODE_AUTO,     4'hF, 1, 0, 12'hF03, 48'hF03_F02_F01_F00, 4'b1000, 1, 0);
        vecs[22] = mk(0, MODE_AUTO,     4'h0, 1, 0, 12'h111, 48'hF03_F02_F01_F00, 4'b0000, 0, 1);
        vecs[23] = mk(0, MODE_EXPLICIT, 4'hF, 0, 0, 12'h000, 48'hF03_F02_F01_F00, 4'b0000, 0, 0);
        vecs[24] = mk(0, MODE_EXPLICIT, 4'hF, 1, 0, 12'h555, 48'hF03_F02_F01_555, 4'b0001, 0, 0);
        vecs[25] = mk(0, MODE_EXPLICIT, 4'hF, 0, 0, 12'h000, 48'hF03_F02_F01_555, 4'b0000, 0, 0);

        @(negedge clk);
        checkOutput("reset data", ifA.out_data, 48'h0);
        checkOutput("reset upd", 48'(ifA.out_upd), 48'h0);
        checkOutput("reset slot", 48'(ifA.slot), 48'h0);
        checkOutput("reset fd", 48'(ifA.frame_done), 48'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d data", i), ifA.out_data, vecs[i].expData);
            checkOutput($sformatf("v%0d upd", i), 48'(ifA.out_upd), 48'(vecs[i].expUpd));
            checkOutput($sformatf("v%0d fd", i), 48'(ifA.frame_done), 48'(vecs[i].expFd));
            checkOutput($sformatf("v%0d err", i), 48'(ifA.sel_err), 48'h0);
            checkOutput($sformatf("v%0d slot", i), 48'(ifA.slot), 48'(vecs[i].expSlot));
        end

        // Three-voice instance: an in_sel of 3 is out of range.
        driveB(1'b1, 2'd0, 12'h555);
        checkOutput("B write data", 48'(ifB.out_data), 48'h000_000_555);
        checkOutput("B write upd", 48'(ifB.out_upd), 48'h1);
        checkOutput("B write err", 48'(ifB.sel_err), 48'h0);
        driveB(1'b1, 2'd3, 12'h777);
        checkOutput("B oor err", 48'(ifB.sel_err), 48'h1);
        checkOutput("B oor upd", 48'(ifB.out_upd), 48'h0);
        checkOutput("B oor data", 48'(ifB.out_data), 48'h000_000_555);
        driveB(1'b0, 2'd0, 12'h000);
        checkOutput("B err pulse", 48'(ifB.sel_err), 48'h0);
        @(negedge clk);
        ifB.voice_en = 3'b011;
        driveB(1'b1, 2'd2, 12'h999);
        checkOutput("B masked err", 48'(ifB.sel_err), 48'h0);
        checkOutput("B masked upd", 48'(ifB.out_upd), 48'h0);
        checkOutput("B masked data", 48'(ifB.out_data), 48'h000_000_555);

        // Reset in the middle of a partial auto frame.
        driveA(1'b1, 12'h201);
        driveA(1'b1, 12'h202);
        checkOutput("pre-reset data", ifA.out_data, 48'hF03_F02_202_201);
        @(negedge clk);
        ifA.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async data", ifA.out_data, 48'h0);
        checkOutput("async upd", 48'(ifA.out_upd), 48'h0);
        checkOutput("async slot", 48'(ifA.slot), 48'h0);
        checkOutput("async fd", 48'(ifA.frame_done), 48'h0);
        checkOutput("async err", 48'(ifA.sel_err), 48'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fdCount = 0;
        for (int i = 0; i < 4; i++) begin
            driveA(1'b1, 12'h301 + 12'(i));
            checkOutput($sformatf("post-reset upd %0d", i), 48'(ifA.out_upd), 48'(4'b0001 << i));
            if (ifA.frame_done) fdCount++;
        end
        checkOutput("post-reset last fd", 48'(ifA.frame_done), 48'h1);
        checkOutput("post-reset fd count", 48'(fdCount), 48'h1);
        checkOutput("post-reset data", ifA.out_data, 48'h304_303_302_301);
        checkOutput("post-reset slot", 48'(ifA.slot), 48'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
